adder_seq_nbit: RTL
===================

# adder_seq_nbit

Multi-cycle, parametrised n-bit add/subtract unit that reuses `adder_nbit` as a CHUNK-bit slice adder. A WIDTH-bit result is produced over WIDTH/CHUNK cycles, with the carry held in a register between slices. Operands enter through a valid/ready handshake and the result leaves through one. It serves datapaths where area matters more than latency and replaces the fixed-width combinational adder wrappers.

## Interface
- `WIDTH`, default 32: operand and result width. Must be a multiple of CHUNK.
- `CHUNK`, default 8: slice width added per cycle. NCHUNK = WIDTH/CHUNK, with NCHUNK ≥ 1.
- `clk`  in  1: the single clock. Everything is rising-edge.
- `rst`  in  1: synchronous reset, active-high.
- `in_valid`  in  1: the operands are valid.
- `in_ready`  out  1: the block accepts operands. Equal to (state==IDLE) && !rst.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `carry_in`  in  1: carry-in for add, borrow-in for sub.
- `sub`  in  1: 0 computes a+b+carry_in; 1 computes a−b−carry_in.
- `out_valid`  out  1: the result is valid. High only in DONE.
- `out_ready`  in  1: the consumer accepts the result.
- `sum`  out  WIDTH: the result (registered).
- `overflow`  out  1: carry-out for add, borrow-out for sub (registered).
- `busy`  out  1: high while state != IDLE.

## Operation
- States, from `adder_pkg::adder_seq_state_t`: IDLE, CALC, DONE.
- **IDLE:** in_valid && in_ready causes these captures:
  - a_r ← a.
  - b_r ← sub ? ~b : b.
  - c_r ← sub ? ~carry_in : carry_in.
  - sub_r ← sub.
  - idx ← 0.
  - Next state is CALC.
- **CALC, each cycle:**
  - The slice adder adds a_r[idx*CHUNK +: CHUNK] + b_r[same] + c_r.
  - The slice sum is written to sum[idx*CHUNK +: CHUNK].
  - c_r ← slice carry-out.
  - idx ← idx+1.
- **CALC exit:** on the cycle where idx == NCHUNK−1:
  - overflow ← sub_r ? ~carry_out : carry_out.
  - Next state is DONE.
- **DONE:** sum and overflow are held stable. out_valid && out_ready returns to IDLE.
- **Arithmetic:** unsigned modulo 2^WIDTH. The overflow bit is the (WIDTH+1)th bit for add and the borrow for sub.
- **Input isolation:** changes to a, b, carry_in or sub after capture have no effect.
- **Ignored requests:** in_valid while busy is ignored; in_ready is 0.
- **sum between operations:** sum keeps the previous result until slices are overwritten in the next CALC. It is meaningful only while out_valid.
- **Reset values:** state=IDLE, idx=0, c_r=0, sum=0, overflow=0, out_valid=0, busy=0. in_ready is 0 during reset and 1 on the first cycle after reset.
- **Reset mid-operation** (CALC or DONE): the operation is abandoned and no out_valid is produced. The next cycle is IDLE with reset values.

## Timing
- **Latency:** operands accepted at edge k → out_valid high after edge k+NCHUNK.
  - Example: WIDTH=32, CHUNK=8 gives 4 cycles.
  - CHUNK=WIDTH gives 1 cycle.
- **Throughput:** at most one operation per NCHUNK+2 cycles: NCHUNK CALC cycles, ≥1 DONE cycle, 1 IDLE cycle.
- **Backpressure:** out_ready low holds DONE indefinitely. sum, overflow and out_valid stay constant.
- **out_ready outside DONE:** has no effect.
- **Combinational paths:** the critical path is one CHUNK-bit ripple plus the slice mux. There are no combinational paths from inputs to outputs except in_ready from rst.

## Configuration
- `ADDER_SEQ_CHECK_EN` defined: the block compiles in a concurrent self-check.
  - While out_valid, it asserts {overflow,sum} equals the expected value.
    - Add: a_cap + b_cap + cin_cap.
    - Sub: the borrow-encoded a_cap − b_cap − cin_cap.
  - On mismatch it reports `$error`.
  - It also asserts that a, b, carry_in and sub are free of X/Z at capture.
- `ADDER_SEQ_CHECK_EN` not defined: no checker logic or shadow registers are present. Functional behaviour is identical.

## Structure
- **Package `adder_pkg`:**
  - `adder_seq_state_t`: enum of IDLE, CALC, DONE.
  - Helper `clog2`-based width constant for idx: max(1, $clog2(NCHUNK)).
- **Sub-module:** one instance of the existing `adder_nbit #(CHUNK)` serves as the slice adder. Its ports are a, b, carry_in, sum, overflow, with overflow used as the slice carry-out.
- Control, capture registers and the result register live in the top.

## Test plan
1. **Carry out of the top bit** (WIDTH=32, CHUNK=8): 0xFFFFFFFF + 0x00000001, cin=0 → sum=0x00000000, overflow=1, out_valid exactly 4 cycles after accept.
2. **Carry across slice boundaries:** 0x00FF00FF + 0x00010001, cin=1 → sum=0x01000101, overflow=0.
3. **Subtraction with and without borrow:**
   - sub=1: 5 − 7, cin=0 → sum=0xFFFFFFFE, overflow=1.
   - 7 − 5, cin=1 → sum=0x00000001, overflow=0.
4. **Backpressure:**
   - Hold out_ready=0 for 10 cycles in DONE → sum, overflow and out_valid are stable, and in_ready=0.
   - Pulse in_valid during this window → it is ignored.
   - Assert out_ready → IDLE on the next cycle.
5. **Reset mid-CALC:** assert rst at the 2nd CALC cycle → next cycle state IDLE, out_valid=0, sum=0, in_ready=1. A following 0x12345678 + 0x11111111 → 0x23456789.
6. **Single-cycle configuration** (WIDTH=CHUNK=16): 0x8000 + 0x8000 → sum=0x0000, overflow=1, out_valid 1 cycle after accept.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adder_pkg
// Brief   : Shared state encoding and sizing helper for the sequential adder.
// Revision: 1.0 - initial release
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } adder_seq_state_t;

    // Slice index width; a single-slice build still needs a 1-bit counter.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_nbit.sv
`default_nettype none
// ============================================================================
// Module  : adder_nbit
// Brief   : Combinational WIDTH-bit adder with carry-in and carry-out.
// Revision: 1.0 - initial release
// ============================================================================
module adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule
`default_nettype wire

// File: rtl/adder_seq_nbit.sv
`default_nettype none
// ============================================================================
// Module  : adder_seq_nbit
// Brief   : Multi-cycle add/subtract, one CHUNK-bit slice per cycle.
//           Optional self-check compiled in with ADDER_SEQ_CHECK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module adder_seq_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    adder_seq_state_t r_state;
    adder_seq_state_t w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic             r_sub;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_ovf;

    logic [31:0]      w_shift;
    logic [WIDTH-1:0] w_mask;
    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK-1:0] w_slice_sum;
    logic             w_slice_carry;
    logic             w_accept;
    logic             w_last;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign overflow  = r_ovf;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST_IDX);

    // Slice selection by shifting keeps every index in range, including CHUNK == WIDTH.
    assign w_shift   = 32'(r_idx) * 32'(CHUNK);
    assign w_a_slice = CHUNK'(r_a >> w_shift);
    assign w_b_slice = CHUNK'(r_b >> w_shift);
    assign w_mask    = WIDTH'({CHUNK{1'b1}}) << w_shift;

    adder_nbit #(
        .WIDTH (CHUNK)
    ) u_slice_adder (
        .a        (w_a_slice),
        .b        (w_b_slice),
        .carry_in (r_c),
        .sum      (w_slice_sum),
        .overflow (w_slice_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_next = CALC;
            CALC:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Subtraction runs as a + ~b + ~borrow; the final carry is inverted back to a borrow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= 1'b0;
            r_sub <= 1'b0;
            r_idx <= '0;
            r_sum <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= sub ? ~b : b;
                        r_c   <= sub ? ~carry_in : carry_in;
                        r_sub <= sub;
                        r_idx <= '0;
                    end
                end
                CALC: begin
                    r_sum <= (r_sum & ~w_mask) | (WIDTH'(w_slice_sum) << w_shift);
                    r_c   <= w_slice_carry;
                    if (w_last) begin
                        r_ovf <= r_sub ^ w_slice_carry;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADDER_SEQ_CHECK_EN
    logic [WIDTH-1:0] r_chk_a;
    logic [WIDTH-1:0] r_chk_b;
    logic             r_chk_cin;
    logic             r_chk_sub;
    logic [WIDTH:0]   w_chk_expect;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_chk_a   <= a;
            r_chk_b   <= b;
            r_chk_cin <= carry_in;
            r_chk_sub <= sub;
        end
    end

    // The extra MSB of a WIDTH+1-bit difference is exactly the borrow.
    assign w_chk_expect = r_chk_sub
        ? ({1'b0, r_chk_a} - {1'b0, r_chk_b} - (WIDTH+1)'(r_chk_cin))
        : ({1'b0, r_chk_a} + {1'b0, r_chk_b} + (WIDTH+1)'(r_chk_cin));

    a_result_ok : assert property (@(posedge clk) disable iff (rst)
        out_valid |-> ({overflow, sum} == w_chk_expect))
        else $error("adder_seq_nbit: result %h expected %h", {overflow, sum}, w_chk_expect);

    a_inputs_known : assert property (@(posedge clk) disable iff (rst)
        w_accept |-> !$isunknown({a, b, carry_in, sub}))
        else $error("adder_seq_nbit: X/Z on operands at capture");
`else
    // Checker disabled: no shadow state is built.
`endif

endmodule
`default_nettype wire
